keypad_debouncer: RTL and testbench
===================================

Name: keypad_debouncer

Overview:
Front-end stage of the safe. Takes the raw 4x3 keypad row/column lines, synchronises and debounces them, and decodes the single pressed key into a 4-bit code. Each debounced press produces exactly one one-cycle strobe. Feeds the safe's digit counter, comparator and state manager with clean key events, replacing direct use of raw row/col levels.

Parameters:
DEBOUNCE_CYCLES, 1000, consecutive stable cycles required to accept a press or a release (minimum 2).
CNT_W, $clog2(DEBOUNCE_CYCLES), width of the debounce counter.
REPEAT_DELAY, 50000, held cycles before the first auto-repeat (used only with KEY_REPEAT_EN).
REPEAT_PERIOD, 10000, cycles between auto-repeats (used only with KEY_REPEAT_EN).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
row1..row4  in  1 each  raw keypad row lines, active-high, asynchronous to clk
col1..col3  in  1 each  raw keypad column lines, active-high, asynchronous to clk
key_code  out  4  last accepted key: 0-9 = digit, 4'hA = '*', 4'hB = '#'
key_valid  out  1  one-cycle strobe; key_code is valid in the same cycle
key_star  out  1  one-cycle strobe, coincident with key_valid when the code is 4'hA
key_hash  out  1  one-cycle strobe, coincident with key_valid when the code is 4'hB
key_release  out  1  one-cycle strobe when a held key's release is accepted
key_held  out  1  level: a key is accepted and not yet released
multi_key  out  1  level, registered: the synchronised lines show more than one row or more than one column

Behaviour:
- Reset (async, active-high):
  - Synchronisers and counters clear to 0; FSM goes to IDLE.
  - key_code = 4'hF; all strobes and levels = 0.
- Synchronisation: 2-flop synchroniser on each of the 7 lines.
- Decode (combinational on synchronised lines):
  - Exactly one row and exactly one column high -> valid code.
  - Map: r1 = 1/2/3; r2 = 4/5/6; r3 = 7/8/9; r4 = '*'/0/'#' (col1/col2/col3).
  - All lines low -> none.
  - Anything else -> invalid; multi_key = 1, registered.
- FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB.
  - IDLE: on a valid code, latch it as the candidate, clear the counter, go to PRESS_DB. Invalid or none: stay in IDLE.
  - PRESS_DB:
    - Same candidate valid: increment the counter.
    - Counter reaches DEBOUNCE_CYCLES-1 with the candidate still valid: go to HELD, register key_code = candidate, pulse key_valid (plus key_star or key_hash if applicable).
    - Candidate changes, goes invalid or goes to none: back to IDLE, no strobe.
  - HELD:
    - All lines low: clear the counter, go to RELEASE_DB.
    - Any other pattern (including a second key or multi-key): stay in HELD, no new strobe.
  - RELEASE_DB:
    - All lines low for DEBOUNCE_CYCLES consecutive cycles: go to IDLE, pulse key_release.
    - Any line high before then: return to HELD, clear the counter, no strobe.
- key_held = 1 in HELD and RELEASE_DB.
- Latency: raw lines stable before edge E1 -> key_valid high in the cycle after edge E(DEBOUNCE_CYCLES+2). With DEBOUNCE_CYCLES = 4, that is after edge 6.
- All strobes are registered, never combinational; only one strobe type can assert per cycle.
- Reset mid-press: all outputs drop immediately. A key still held after reset deassertion is re-debounced and produces a fresh key_valid.
- Counter never wraps: it saturates and is cleared on every state entry.

Optional Feature:
KEY_REPEAT_EN
- Defined: while in HELD, after REPEAT_DELAY cycles, key_valid (and key_star/key_hash) re-pulses every REPEAT_PERIOD cycles with the same key_code. The repeat counter clears on leaving HELD.
- Undefined: exactly one key_valid per press; repeat parameters and counter are not compiled.

Decomposition:
- Shared package safe_pkg:
  - constants KEY_STAR = 4'hA, KEY_HASH = 4'hB, KEY_NONE = 4'hF;
  - typedef kp_state_t (IDLE, PRESS_DB, HELD, RELEASE_DB).
- One sub-module: keypad_sync, a 7-bit two-flop synchroniser with async reset.

Test Plan:
- DEBOUNCE_CYCLES = 4; hold row2+col2 steady -> one key_valid after edge 6, key_code = 5, key_held = 1; release -> key_release after 4 low cycles, key_held = 0.
- row1+col3 bounces (high 2 cycles, low 1, high steady) -> single key_valid with key_code = 3, timed from the last stable edge.
- row4+col1 -> key_code = 4'hA with key_star and key_valid pulsed together; row4+col3 -> 4'hB with key_hash.
- Hold row1+col1, then add row2 while HELD -> multi_key = 1, no second key_valid; drop all lines -> exactly one key_release.
- Assert reset mid-PRESS_DB with key 7 held -> outputs 0 and key_code = 4'hF; key held through reset deassertion -> one key_valid, code 7.
- KEY_REPEAT_EN with REPEAT_DELAY = 20, REPEAT_PERIOD = 5; hold key 9 for 40 cycles -> key_valid at accept, accept+20, accept+25, accept+30, and so on.

Source files
------------

// File: rtl/safe_pkg.sv
// Shared definitions for the safe's keypad front end.
//   KEY_STAR / KEY_HASH : key codes reported for '*' and '#'
//   KEY_NONE            : key_code value when no key has been accepted
//   kp_state_t          : debouncer FSM state encoding
package safe_pkg;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;
    localparam logic [3:0] KEY_NONE = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } kp_state_t;

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for the raw keypad lines.
//   clk   in   system clock
//   reset in   asynchronous active-high reset, clears both stages to 0
//   din   in   W raw lines, asynchronous to clk
//   dout  out  W synchronised lines (two cycles of latency)
module keypad_sync #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q;

endmodule

// File: rtl/keypad_debouncer.sv
// Keypad front end: synchronises the 4x3 row/column lines, debounces a
// single pressed key and reports it as a 4-bit code with one-cycle strobes.
//   clk, reset        clock; asynchronous active-high reset
//   row1..row4        raw row lines, active-high
//   col1..col3        raw column lines, active-high
//   key_code          last accepted key (0-9, 4'hA '*', 4'hB '#', 4'hF none)
//   key_valid         one-cycle strobe, key_code valid in the same cycle
//   key_star/key_hash one-cycle strobes coincident with key_valid
//   key_release       one-cycle strobe when a release is accepted
//   key_held          level, a key is accepted and not yet released
//   multi_key         level, synchronised lines show an ambiguous pattern
// Optional build macro KEY_REPEAT_EN: auto-repeat of key_valid while held,
// first after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles
// (REPEAT_DELAY must be >= REPEAT_PERIOD).
module keypad_debouncer
    import safe_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
`ifdef KEY_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 50000,
    parameter int REPEAT_PERIOD   = 10000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       row1,
    input  logic       row2,
    input  logic       row3,
    input  logic       row4,
    input  logic       col1,
    input  logic       col2,
    input  logic       col3,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_star,
    output logic       key_hash,
    output logic       key_release,
    output logic       key_held,
    output logic       multi_key
);

    // The state entry counts as the first stable sample, so the final
    // accepting sample is seen with the counter at DEBOUNCE_CYCLES-2.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic [6:0] sync_lines;
    logic [3:0] rows;
    logic [2:0] cols;
    logic [3:0] dec_code;
    logic       dec_valid;
    logic       lines_none;

    kp_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             star_q, star_d;
    logic             hash_q, hash_d;
    logic             release_q, release_d;
    logic             multi_q, multi_d;

`ifdef KEY_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [REP_W-1:0] REP_FIRE   = REP_W'(REPEAT_DELAY - 1);
    // Reload so the next fire lands REPEAT_PERIOD cycles after this one.
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

    keypad_sync #(.W(7)) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   ({col3, col2, col1, row4, row3, row2, row1}),
        .dout  (sync_lines)
    );

    assign rows       = sync_lines[3:0];
    assign cols       = sync_lines[6:4];
    assign lines_none = (sync_lines == 7'd0);
    assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // Only exactly one row plus exactly one column decodes to a key.
    always_comb begin
        dec_code = KEY_NONE;
        case ({rows, cols})
            {4'b0001, 3'b001}: dec_code = 4'd1;
            {4'b0001, 3'b010}: dec_code = 4'd2;
            {4'b0001, 3'b100}: dec_code = 4'd3;
            {4'b0010, 3'b001}: dec_code = 4'd4;
            {4'b0010, 3'b010}: dec_code = 4'd5;
            {4'b0010, 3'b100}: dec_code = 4'd6;
            {4'b0100, 3'b001}: dec_code = 4'd7;
            {4'b0100, 3'b010}: dec_code = 4'd8;
            {4'b0100, 3'b100}: dec_code = 4'd9;
            {4'b1000, 3'b001}: dec_code = KEY_STAR;
            {4'b1000, 3'b010}: dec_code = 4'd0;
            {4'b1000, 3'b100}: dec_code = KEY_HASH;
            default:           dec_code = KEY_NONE;
        endcase
    end

    assign dec_valid = (dec_code != KEY_NONE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cand_d    = cand_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        release_d = 1'b0;
        multi_d   = !lines_none && !dec_valid;
`ifdef KEY_REPEAT_EN
        rep_cnt_d = '0;
`endif
        case (state_q)
            IDLE: begin
                if (dec_valid) begin
                    cand_d  = dec_code;
                    cnt_d   = '0;
                    state_d = PRESS_DB;
                end
            end
            PRESS_DB: begin
                if (dec_valid && (dec_code == cand_q)) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = HELD;
                        code_d  = cand_q;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            HELD: begin
                if (lines_none) begin
                    state_d = RELEASE_DB;
                    cnt_d   = '0;
                end else begin
`ifdef KEY_REPEAT_EN
                    if (rep_cnt_q == REP_FIRE) begin
                        valid_d   = 1'b1;
                        rep_cnt_d = REP_RELOAD;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
`endif
                end
            end
            RELEASE_DB: begin
                if (lines_none) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d   = IDLE;
                        release_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    state_d = HELD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        star_d = valid_d && (code_d == KEY_STAR);
        hash_d = valid_d && (code_d == KEY_HASH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cand_q    <= KEY_NONE;
            code_q    <= KEY_NONE;
            valid_q   <= 1'b0;
            star_q    <= 1'b0;
            hash_q    <= 1'b0;
            release_q <= 1'b0;
            multi_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cand_q    <= cand_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            star_q    <= star_d;
            hash_q    <= hash_d;
            release_q <= release_d;
            multi_q   <= multi_d;
`ifdef KEY_REPEAT_EN
            rep_cnt_q <= rep_cnt_d;
`endif
        end
    end

    assign key_code    = code_q;
    assign key_valid   = valid_q;
    assign key_star    = star_q;
    assign key_hash    = hash_q;
    assign key_release = release_q;
    assign key_held    = (state_q == HELD) || (state_q == RELEASE_DB);
    assign multi_key   = multi_q;

endmodule

// File: tb/tb_keypad_debouncer.sv
// Randomised and directed bench for keypad_debouncer with DEBOUNCE_CYCLES=4.
// The reference model works on debounce run lengths: a key is accepted after
// D consecutive identical valid samples, released after D consecutive empty
// samples. Build with KEY_REPEAT_EN to include the auto-repeat checks.
module tb_keypad_debouncer;

    localparam int D = 4;
`ifdef KEY_REPEAT_EN
    localparam int RD = 20;
    localparam int RP = 5;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rows_r;
    logic [2:0] cols_r;
    logic [3:0] key_code;
    logic       key_valid, key_star, key_hash, key_release, key_held, multi_key;

    always #5 clk = ~clk;

    keypad_debouncer #(
        .DEBOUNCE_CYCLES (D)
`ifdef KEY_REPEAT_EN
        ,
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .row1        (rows_r[0]),
        .row2        (rows_r[1]),
        .row3        (rows_r[2]),
        .row4        (rows_r[3]),
        .col1        (cols_r[0]),
        .col2        (cols_r[1]),
        .col3        (cols_r[2]),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_star    (key_star),
        .key_hash    (key_hash),
        .key_release (key_release),
        .key_held    (key_held),
        .multi_key   (multi_key)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;
    int n_rel   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0] m_s1, m_s2;
    bit         m_held;
    int         m_streak, m_low, m_t;
    logic [3:0] m_cand, m_code;
    bit         e_valid, e_rel, e_multi;

    function automatic logic [3:0] key_of(input logic [3:0] r, input logic [2:0] c);
        int ri, ci;
        ri = 0;
        ci = 0;
        if ($countones(r) != 1 || $countones(c) != 1) return 4'hF;
        for (int i = 0; i < 4; i++) if (r[i]) ri = i;
        for (int j = 0; j < 3; j++) if (c[j]) ci = j;
        if (ri < 3) return 4'(ri * 3 + ci + 1);
        return (ci == 0) ? 4'hA : (ci == 1) ? 4'h0 : 4'hB;
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_held = 0; m_streak = 0; m_low = 0; m_t = 0;
        m_cand = 4'hF; m_code = 4'hF; e_valid = 0; e_rel = 0; e_multi = 0;
    endtask

    task automatic model_step();
        logic [6:0] smp;
        logic [3:0] k;
        bit         v, none;
        if (reset) begin
            model_reset();
            return;
        end
        smp  = m_s2;
        m_s2 = m_s1;
        m_s1 = {cols_r, rows_r};
        k    = key_of(smp[3:0], smp[6:4]);
        v    = (k != 4'hF);
        none = (smp == 7'd0);
        e_valid = 0;
        e_rel   = 0;
        e_multi = !none && !v;
        if (!m_held) begin
            if (v && m_streak > 0 && k == m_cand) m_streak++;
            else if (v) begin m_streak = 1; m_cand = k; end
            else m_streak = 0;
            if (m_streak == D) begin
                m_held = 1; m_code = m_cand; e_valid = 1;
                m_streak = 0; m_low = 0; m_t = 0;
            end
        end else if (none) begin
            m_low++;
            if (m_low == D) begin
                m_held = 0; e_rel = 1; m_low = 0;
            end
        end else if (m_low > 0) begin
            m_low = 0;
            m_t   = 0;
        end else begin
            m_t++;
`ifdef KEY_REPEAT_EN
            if (m_t >= RD && (m_t - RD) % RP == 0) e_valid = 1;
`endif
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_keys(input logic [3:0] r, input logic [2:0] c);
        rows_r = r;
        cols_r = c;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("outs",
            32'({key_code, key_valid, key_star, key_hash, key_release, key_held, multi_key}),
            32'({m_code, e_valid, e_valid && m_code == 4'hA, e_valid && m_code == 4'hB,
                 e_rel, m_held, e_multi}));
        if (key_valid) n_valid++;
        if (key_release) n_rel++;
    endtask

    task automatic wait_ev(input bit rel, input int maxc, output int lat);
        lat = -1;
        for (int i = 1; i <= maxc; i++) begin
            tick();
            if (rel ? key_release : key_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic press_release(input logic [3:0] r, input logic [2:0] c, input string tag,
                                 input logic [3:0] exp_code);
        int lat;
        set_keys(r, c);
        wait_ev(0, 12, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(6));
        chk({tag, "_code"}, 32'(key_code), 32'(exp_code));
        chk({tag, "_star"}, 32'(key_star), 32'(exp_code == 4'hA));
        chk({tag, "_hash"}, 32'(key_hash), 32'(exp_code == 4'hB));
        set_keys(4'b0, 3'b0);
        wait_ev(1, 12, lat);
        chk({tag, "_rel_lat"}, 32'(lat), 32'(6));
    endtask

    initial begin
        int lat;
        logic [3:0] pr, nr;
        logic [2:0] pc, nc;
        reset = 1'b1;
        set_keys(4'b0, 3'b0);
        model_reset();
        @(negedge clk);
        chk("reset_outs",
            32'({key_code, key_valid, key_star, key_hash, key_release, key_held, multi_key}),
            32'({4'hF, 6'b0}));
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();

        // key 5: one strobe after edge 6, held, released after 4 low samples
        n_valid = 0;
        set_keys(4'b0010, 3'b010);
        wait_ev(0, 12, lat);
        chk("k5_lat", 32'(lat), 32'(6));
        chk("k5_code", 32'(key_code), 32'(5));
        chk("k5_held", 32'(key_held), 32'(1));
        repeat (10) tick();
        chk("k5_once", 32'(n_valid), 32'(1));
        set_keys(4'b0, 3'b0);
        wait_ev(1, 12, lat);
        chk("k5_rel_lat", 32'(lat), 32'(6));
        chk("k5_unheld", 32'(key_held), 32'(0));
        repeat (3) tick();

        // key 3 with bounce: high 2, low 1, then steady
        n_valid = 0;
        set_keys(4'b0001, 3'b100);
        tick(); tick();
        set_keys(4'b0, 3'b0);
        tick();
        press_release(4'b0001, 3'b100, "k3", 4'd3);
        chk("k3_once", 32'(n_valid), 32'(1));
        repeat (3) tick();

        press_release(4'b1000, 3'b001, "star", 4'hA);
        repeat (3) tick();
        press_release(4'b1000, 3'b100, "hash", 4'hB);
        repeat (3) tick();

        // second row added while held
        n_valid = 0;
        n_rel   = 0;
        set_keys(4'b0001, 3'b001);
        wait_ev(0, 12, lat);
        set_keys(4'b0011, 3'b001);
        repeat (8) tick();
        chk("multi_lvl", 32'(multi_key), 32'(1));
        chk("multi_held", 32'(key_held), 32'(1));
        chk("multi_code", 32'(key_code), 32'(1));
        chk("multi_once", 32'(n_valid), 32'(1));
        set_keys(4'b0, 3'b0);
        repeat (12) tick();
        chk("multi_rel", 32'(n_rel), 32'(1));

        // reset during press debounce of key 7
        set_keys(4'b0100, 3'b001);
        repeat (4) tick();
        #2 reset = 1'b1;
        #1 chk("rst_mid",
               32'({key_code, key_valid, key_star, key_hash, key_release, key_held, multi_key}),
               32'({4'hF, 6'b0}));
        tick();
        tick();
        reset   = 1'b0;
        n_valid = 0;
        wait_ev(0, 12, lat);
        chk("k7_lat", 32'(lat), 32'(6));
        chk("k7_code", 32'(key_code), 32'(7));
        repeat (10) tick();
        chk("k7_once", 32'(n_valid), 32'(1));
        set_keys(4'b0, 3'b0);
        repeat (10) tick();

        // key 9 held for 40 cycles after acceptance
        n_valid = 0;
        set_keys(4'b0100, 3'b100);
        wait_ev(0, 12, lat);
        chk("k9_code", 32'(key_code), 32'(9));
        begin
            int offs[$];
            for (int i = 1; i <= 40; i++) begin
                tick();
                if (key_valid) offs.push_back(i);
            end
`ifdef KEY_REPEAT_EN
            chk("rep_count", 32'(offs.size()), 32'((40 - RD) / RP + 1));
            foreach (offs[k]) chk("rep_at", 32'(offs[k]), 32'(RD + k * RP));
`else
            chk("no_repeat", 32'(offs.size()), 32'(0));
`endif
        end
        set_keys(4'b0, 3'b0);
        repeat (10) tick();

        // randomised segments, checked cycle by cycle against the model
        pr = 4'b0;
        pc = 3'b0;
        for (int s = 0; s < 400; s++) begin
            int sel, dur;
            sel = int'($urandom_range(0, 9));
            if (sel < 4) begin
                nr = 4'b0; nc = 3'b0;
            end else if (sel < 8) begin
                nr = 4'(1 << $urandom_range(0, 3));
                nc = 3'(1 << $urandom_range(0, 2));
            end else begin
                nr = 4'($urandom_range(0, 15));
                nc = 3'($urandom_range(0, 7));
            end
            // a direct switch between two different keys always passes
            // through an empty cycle
            if (key_of(pr, pc) != 4'hF && key_of(nr, nc) != 4'hF &&
                key_of(pr, pc) != key_of(nr, nc)) begin
                set_keys(4'b0, 3'b0);
                tick();
            end
            set_keys(nr, nc);
            dur = ($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 60))
                                              : int'($urandom_range(1, 12));
            repeat (dur) tick();
            pr = nr;
            pc = nc;
        end
        set_keys(4'b0, 3'b0);
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1);
    end

endmodule
